// File: rtl/p4_frame_merge_if.sv
// AXI-Stream link used for the header, payload and merged output streams of p4_frame_merge.
interface p4_frame_merge_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/p4_frame_merge.sv
// Re-serialises a header frame followed by its payload frame into one AXI-Stream frame.
// Optional statistics counters are built when P4_FRAME_MERGE_STATS_EN is defined.
module p4_frame_merge #(
    parameter int DATA_WIDTH  = 64,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter bit ID_ENABLE   = 1'b0,
    parameter int ID_WIDTH    = 8,
    parameter bit DEST_ENABLE = 1'b0,
    parameter int DEST_WIDTH  = 8,
    parameter bit USER_ENABLE = 1'b1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    p4_frame_merge_if.slave       s_axis_hdr,
    p4_frame_merge_if.slave       s_axis,
    p4_frame_merge_if.master      m_axis,
    input  logic                  enable,
    output logic                  busy,
    output logic [31:0]           status_frame_count,
    output logic [31:0]           status_error_count
);

    typedef enum logic [1:0] {StIdle, StHdr, StPld} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DEST_WIDTH-1:0] dest_q, dest_d;
    logic                  err_q, err_d;

    beat_t main_q, temp_q, in_beat;
    logic  main_valid_q, temp_valid_q;
    logic  in_valid, hdr_ready, pld_ready, in_xfer;

    // Input readiness depends only on registered state: active state and a free skid slot.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        dest_d    = dest_q;
        err_d     = err_q;
        in_valid  = 1'b0;
        in_beat   = '0;
        hdr_ready = 1'b0;
        pld_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && s_axis_hdr.tvalid) begin
                    state_d = StHdr;
                    id_d    = s_axis_hdr.tid;
                    dest_d  = s_axis_hdr.tdest;
                end
            end
            StHdr: begin
                hdr_ready    = !temp_valid_q;
                in_valid     = s_axis_hdr.tvalid;
                in_beat.data = s_axis_hdr.tdata;
                in_beat.keep = KEEP_ENABLE ? s_axis_hdr.tkeep : {KEEP_WIDTH{1'b1}};
                in_beat.last = 1'b0;
                in_beat.id   = ID_ENABLE ? id_q : '0;
                in_beat.dest = DEST_ENABLE ? dest_q : '0;
                in_beat.user = USER_ENABLE ? s_axis_hdr.tuser : '0;
                if (hdr_ready && s_axis_hdr.tvalid) begin
                    err_d = err_q | in_beat.user[0];
                    if (s_axis_hdr.tlast) begin
                        state_d = StPld;
                    end
                end
            end
            StPld: begin
                pld_ready    = !temp_valid_q;
                in_valid     = s_axis.tvalid;
                in_beat.data = s_axis.tdata;
                in_beat.keep = KEEP_ENABLE ? s_axis.tkeep : {KEEP_WIDTH{1'b1}};
                in_beat.last = s_axis.tlast;
                in_beat.id   = ID_ENABLE ? id_q : '0;
                in_beat.dest = DEST_ENABLE ? dest_q : '0;
                in_beat.user = USER_ENABLE ? s_axis.tuser : '0;
                if (s_axis.tlast) begin
                    in_beat.user[0] = in_beat.user[0] | err_q;
                end
                if (pld_ready && s_axis.tvalid && s_axis.tlast) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_xfer = in_valid && (hdr_ready || pld_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            id_q    <= '0;
            dest_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
        end
    end

    // Two-entry skid: temp only fills when main is stalled, and input readiness drops
    // while temp is occupied, so an accepted beat always has a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            temp_q       <= '0;
            temp_valid_q <= 1'b0;
        end else if (!main_valid_q || m_axis.tready) begin
            if (temp_valid_q) begin
                main_q       <= temp_q;
                main_valid_q <= 1'b1;
                temp_valid_q <= 1'b0;
            end else begin
                main_valid_q <= in_xfer;
                if (in_xfer) begin
                    main_q <= in_beat;
                end
            end
        end else if (in_xfer) begin
            temp_q       <= in_beat;
            temp_valid_q <= 1'b1;
        end
    end

    assign s_axis_hdr.tready = hdr_ready;
    assign s_axis.tready     = pld_ready;

    assign m_axis.tvalid = main_valid_q;
    assign m_axis.tdata  = main_q.data;
    assign m_axis.tkeep  = main_q.keep;
    assign m_axis.tlast  = main_q.last;
    assign m_axis.tid    = main_q.id;
    assign m_axis.tdest  = main_q.dest;
    assign m_axis.tuser  = main_q.user;

    assign busy = (state_q != StIdle);

`ifdef P4_FRAME_MERGE_STATS_EN
    logic [31:0] frame_cnt_q, err_cnt_q;
    logic        pld_done;

    assign pld_done = pld_ready && s_axis.tvalid && s_axis.tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (pld_done) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
            if (in_beat.user[0]) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign status_frame_count = frame_cnt_q;
    assign status_error_count = err_cnt_q;
`else
    assign status_frame_count = '0;
    assign status_error_count = '0;
`endif

endmodule

// File: tb/tb_p4_frame_merge.sv
// Randomised and directed bench for p4_frame_merge against a frame-level reference model.
module tb_p4_frame_merge;

    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int IW  = 8;
    localparam int DSW = 8;
    localparam int UW  = 1;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        busy;
    logic [31:0] status_frame_count, status_error_count;

    p4_frame_merge_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
                        .USER_WIDTH(UW)) hdr_if ();
    p4_frame_merge_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
                        .USER_WIDTH(UW)) pld_if ();
    p4_frame_merge_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
                        .USER_WIDTH(UW)) out_if ();

    p4_frame_merge #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .ID_ENABLE  (1'b1),
        .ID_WIDTH   (IW),
        .DEST_ENABLE(1'b1),
        .DEST_WIDTH (DSW),
        .USER_ENABLE(1'b1),
        .USER_WIDTH (UW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_hdr        (hdr_if),
        .s_axis            (pld_if),
        .m_axis            (out_if),
        .enable            (enable),
        .busy              (busy),
        .status_frame_count(status_frame_count),
        .status_error_count(status_error_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    beat_t hdr_q[$];
    beat_t pld_q[$];
    beat_t exp_q[$];
    int    fire_cyc[$];
    int    rdy_pat[$];

    int    mdl_frames = 0;
    int    mdl_errs = 0;
    int    cyc = 0;
    int    pld_fires = 0;
    int    hdr_done = 0;
    int    pld_done = 0;
    int    early_cnt = 0;
    int    ready_mode = 0;
    bit    hdr_gate = 1'b1;
    bit    pld_gate = 1'b1;
    bit    rand_gaps = 1'b0;
    bit    rand_en = 1'b0;
    bit    hold_prev = 1'b0;
    bit    busy_seen = 1'b0;
    beat_t held_beat;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: header beats verbatim (tlast cleared), then payload beats; sideband
    // from the first header beat; any header tuser[0] folds into the payload tlast beat.
    task automatic add_frame(input int nh, input int np, input logic [63:0] hbase,
                             input logic [63:0] pbase, input logic [7:0] id,
                             input logic [7:0] dest, input logic [31:0] hmask,
                             input logic [31:0] pmask, input bit rnd);
        beat_t b, e;
        logic  err;
        err = 1'b0;
        for (int i = 0; i < nh; i++) begin
            b.data = rnd ? {$urandom, $urandom} : hbase + 64'(i);
            b.keep = rnd ? 8'($urandom) : 8'hff;
            b.last = (i == nh - 1);
            b.id   = (i == 0) ? id : 8'($urandom);
            b.dest = (i == 0) ? dest : 8'($urandom);
            b.user = hmask[i];
            hdr_q.push_back(b);
            e = b;
            e.last = 1'b0;
            e.id   = id;
            e.dest = dest;
            err    = err | b.user[0];
            exp_q.push_back(e);
        end
        for (int j = 0; j < np; j++) begin
            b.data = rnd ? {$urandom, $urandom} : pbase + 64'(j);
            b.keep = rnd ? 8'($urandom) : 8'hff;
            b.last = (j == np - 1);
            b.id   = 8'($urandom);
            b.dest = 8'($urandom);
            b.user = pmask[j];
            pld_q.push_back(b);
            e = b;
            e.id   = id;
            e.dest = dest;
            if (b.last) begin
                e.user[0] = e.user[0] | err;
                mdl_frames++;
                if (e.user[0]) mdl_errs++;
            end
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample at negedge, drive just after posedge.
    task automatic step();
        beat_t ob, b;
        logic  hf, pf, of, hv, pv;
        @(negedge clk);
        hf = hdr_if.tvalid && hdr_if.tready;
        pf = pld_if.tvalid && pld_if.tready;
        of = out_if.tvalid && out_if.tready;
        ob.data = out_if.tdata;
        ob.keep = out_if.tkeep;
        ob.last = out_if.tlast;
        ob.id   = out_if.tid;
        ob.dest = out_if.tdest;
        ob.user = out_if.tuser;
        if (hold_prev) check("hold_stable", 128'(ob), 128'(held_beat));
        if (of) begin
            if (exp_q.size() == 0) check("extra_beat", 128'(1), 128'(0));
            else check("beat", 128'(ob), 128'(exp_q.pop_front()));
            fire_cyc.push_back(cyc);
        end
        hold_prev = out_if.tvalid && !out_if.tready;
        held_beat = ob;
        if (busy) busy_seen = 1'b1;
        if (hf && hdr_if.tlast) hdr_done++;
        if (pf) begin
            pld_fires++;
            if (hdr_done == pld_done) early_cnt++;
            if (pld_if.tlast) pld_done++;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (hf) hdr_q.delete(0);
        if (pf) pld_q.delete(0);
        hv = (hdr_q.size() > 0) && ((hdr_if.tvalid && !hf) ||
             (hdr_gate && (!rand_gaps || $urandom_range(3) != 0)));
        pv = (pld_q.size() > 0) && ((pld_if.tvalid && !pf) ||
             (pld_gate && (!rand_gaps || $urandom_range(3) != 0)));
        hdr_if.tvalid = hv;
        if (hv) begin
            b = hdr_q[0];
            hdr_if.tdata = b.data; hdr_if.tkeep = b.keep; hdr_if.tlast = b.last;
            hdr_if.tid = b.id; hdr_if.tdest = b.dest; hdr_if.tuser = b.user;
        end
        pld_if.tvalid = pv;
        if (pv) begin
            b = pld_q[0];
            pld_if.tdata = b.data; pld_if.tkeep = b.keep; pld_if.tlast = b.last;
            pld_if.tid = b.id; pld_if.tdest = b.dest; pld_if.tuser = b.user;
        end
        if (ready_mode == 1) out_if.tready = ($urandom_range(3) != 0);
        else if (ready_mode == 2) out_if.tready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
        else out_if.tready = 1'b1;
        if (rand_en) enable = ($urandom_range(4) != 0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            step();
            n++;
        end
        check({tag, "_left"}, 128'(exp_q.size()), 128'(0));
        repeat (3) step();
        check({tag, "_order"}, 128'(early_cnt), 128'(0));
    endtask

    task automatic check_stats(input string tag);
`ifdef P4_FRAME_MERGE_STATS_EN
        check({tag, "_frames"}, 128'(status_frame_count), 128'(mdl_frames));
        check({tag, "_errors"}, 128'(status_error_count), 128'(mdl_errs));
`else
        check({tag, "_frames"}, 128'(status_frame_count), 128'(0));
        check({tag, "_errors"}, 128'(status_error_count), 128'(0));
`endif
    endtask

    initial begin
        int base;
        hdr_if.tvalid = 1'b0; hdr_if.tdata = '0; hdr_if.tkeep = '0; hdr_if.tlast = 1'b0;
        hdr_if.tid = '0; hdr_if.tdest = '0; hdr_if.tuser = '0;
        pld_if.tvalid = 1'b0; pld_if.tdata = '0; pld_if.tkeep = '0; pld_if.tlast = 1'b0;
        pld_if.tid = '0; pld_if.tdest = '0; pld_if.tuser = '0;
        out_if.tready = 1'b1;

        #12;
        check("rst_tvalid", 128'(out_if.tvalid), 128'(0));
        check("rst_tdata", 128'(out_if.tdata), 128'(0));
        check("rst_side", 128'({out_if.tkeep, out_if.tlast, out_if.tid, out_if.tdest,
              out_if.tuser}), 128'(0));
        check("rst_hdr_tready", 128'(hdr_if.tready), 128'(0));
        check("rst_pld_tready", 128'(pld_if.tready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check_stats("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enable = 1'b1;

        // Basic 2+3 frame, full throughput.
        fire_cyc.delete();
        busy_seen = 1'b0;
        add_frame(2, 3, 64'hA1, 64'hB1, 8'h11, 8'd3, 32'h0, 32'h0, 1'b0);
        drain("basic");
        check("basic_beats", 128'(fire_cyc.size()), 128'(5));
        if (fire_cyc.size() == 5) check("basic_b2b", 128'(fire_cyc[4] - fire_cyc[0]), 128'(4));
        check("basic_busy_seen", 128'(busy_seen), 128'(1));
        check("basic_busy_fell", 128'(busy), 128'(0));

        // Payload presented before header.
        hdr_gate = 1'b0;
        add_frame(1, 3, 64'hC0, 64'hD0, 8'h22, 8'd5, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("early_pld_tready", 128'(pld_if.tready), 128'(0));
        end
        hdr_gate = 1'b1;
        drain("early");

        // Output backpressure 1,0,0,1 in the middle of the payload.
        ready_mode = 2;
        rdy_pat = '{1, 1, 1, 1, 0, 0, 1, 1, 0, 1};
        add_frame(1, 4, 64'hE0, 64'hF0, 8'h33, 8'd7, 32'h0, 32'h0, 1'b0);
        drain("stall");
        ready_mode = 0;

        // Header error folds into payload tlast.
        add_frame(2, 2, 64'h100, 64'h200, 8'h44, 8'd1, 32'h1, 32'h0, 1'b0);
        drain("err");
        check_stats("err");

        // Enable low keeps the frame from starting.
        enable = 1'b0;
        add_frame(1, 1, 64'h300, 64'h400, 8'h55, 8'd2, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("dis_hdr_tready", 128'(hdr_if.tready), 128'(0));
            check("dis_tvalid", 128'(out_if.tvalid), 128'(0));
        end
        enable = 1'b1;
        step();
        check("en_busy", 128'(busy), 128'(1));
        drain("en");

        // Reset between payload beats 2 and 3.
        add_frame(1, 5, 64'h500, 64'h600, 8'h66, 8'd4, 32'h0, 32'h0, 1'b0);
        base = pld_fires;
        for (int i = 0; i < 50 && pld_fires < base + 2; i++) step();
        check("rst_mid_reached", 128'(pld_fires - base), 128'(2));
        rst_n = 1'b0;
        #1;
        check("rst_mid_tvalid", 128'(out_if.tvalid), 128'(0));
        check("rst_mid_tdata", 128'(out_if.tdata), 128'(0));
        check("rst_mid_tready", 128'({hdr_if.tready, pld_if.tready}), 128'(0));
        check("rst_mid_busy", 128'(busy), 128'(0));
        check("rst_mid_cnt", 128'({status_frame_count, status_error_count}), 128'(0));
        hdr_q.delete(); pld_q.delete(); exp_q.delete();
        hdr_if.tvalid = 1'b0; pld_if.tvalid = 1'b0;
        hold_prev = 1'b0; hdr_done = 0; pld_done = 0; mdl_frames = 0; mdl_errs = 0;
        repeat (2) step();
        rst_n = 1'b1;
        add_frame(2, 2, 64'h700, 64'h800, 8'h77, 8'd6, 32'h2, 32'h1, 1'b0);
        drain("post_rst");
        check_stats("post_rst");

        // Randomised frames with gaps, backpressure and enable toggling.
        ready_mode = 1;
        rand_gaps = 1'b1;
        rand_en = 1'b1;
        for (int f = 0; f < 25; f++) begin
            add_frame(int'($urandom_range(4, 1)), int'($urandom_range(6, 1)), 64'h0, 64'h0,
                      8'($urandom), 8'($urandom), 32'($urandom_range(15) == 0),
                      32'($urandom), 1'b1);
        end
        drain("rand");
        rand_en = 1'b0;
        enable = 1'b1;
        check_stats("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
